dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters:
  - the commit stage, which issues committed store writes;
  - the load unit, which issues speculative load reads tagged with a ROB address.
- Grants one transaction at a time and holds the memory signals stable until dmem_resp.
- Returns the response to the owning requester. Suppresses load responses that a pipeline flush has invalidated.

Parameters:
DATA_WIDTH, 16, memory data and address width
TAG_WIDTH, 3, ROB tag width (matches lc3b_rob_addr)
STARVE_LIMIT, 4, consecutive store grants allowed while a load waits

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
st_req  in  1  commit store request; held until st_resp
st_addr  in  DATA_WIDTH  store address
st_wdata  in  DATA_WIDTH  store data
st_wmask  in  2  byte enables (STB: one bit, STR: 2'b11)
st_resp  out  1  one-cycle store completion pulse
ld_req  in  1  load request; held until ld_resp or flush
ld_addr  in  DATA_WIDTH  load address
ld_tag  in  TAG_WIDTH  ROB tag of the load
ld_resp  out  1  one-cycle load completion pulse
ld_rdata  out  DATA_WIDTH  load data, valid with ld_resp
ld_tag_out  out  TAG_WIDTH  tag of the completing load
flush  in  1  misprediction flush from commit
dmem_read  out  1  memory read strobe
dmem_write  out  1  memory write strobe
dmem_address  out  DATA_WIDTH  memory address
dmem_wdata  out  DATA_WIDTH  memory write data
dmem_wmask  out  2  memory byte enables
dmem_resp  in  1  memory completion
dmem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- Clock and reset: all state is clocked by clk. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE, starve_cnt = 0, all latched fields = 0;
  - dmem_read, dmem_write, st_resp and ld_resp are all 0.
- Reset mid-transaction: abandons the transaction immediately. No response is ever issued for it.
- FSM states and transitions:
  - IDLE:
    - grant decision each cycle; the winner's addr/wdata/wmask/tag is latched and state moves to STORE or LOAD;
    - if flush is high in IDLE, no load is granted that cycle; a store may still be granted.
  - STORE:
    - dmem_write = 1; memory outputs come from the latched registers;
    - on dmem_resp: st_resp = 1 in the same cycle (combinational), then go to IDLE;
    - flush is ignored, because committed stores always complete.
  - LOAD:
    - dmem_read = 1; dmem_wmask = 0;
    - on dmem_resp without flush: ld_resp = 1, ld_rdata = dmem_rdata, ld_tag_out = latched tag, then go to IDLE;
    - flush without dmem_resp: go to LOAD_DRAIN;
    - flush together with dmem_resp: ld_resp is suppressed; go to IDLE.
  - LOAD_DRAIN:
    - dmem_read stays 1 (the memory transaction cannot be aborted); ld_resp is never asserted;
    - on dmem_resp, go to IDLE.
- Grant policy (evaluated in IDLE):
  - store only: grant store;
  - load only (and no flush): grant load;
  - both: grant store unless starve_cnt == STARVE_LIMIT, in which case grant load.
- Starve counter:
  - increments on a store grant made while ld_req is high, saturating at STARVE_LIMIT;
  - clears on any load grant, or on a store grant made while ld_req is low.
- Latency:
  - request seen in IDLE at cycle N: memory strobe is asserted at N+1;
  - the cycle after dmem_resp is always IDLE, so back-to-back transactions are spaced by at least one dead cycle;
  - a request still asserted in that IDLE cycle is treated as new.
- Stability: dmem_address, dmem_wdata and dmem_wmask are driven only from latched registers. They are constant for the whole transaction even if requester inputs change.
- Responses: st_resp and ld_resp are never asserted in the same cycle. Neither is asserted outside the STORE or LOAD states.

Decomposition:
- Shared package:
  - add a state enum dmem_arb_state_t {IDLE, STORE, LOAD, LOAD_DRAIN};
  - add lc3b_mem_wmask (2 bits);
  - reuse lc3b_word and lc3b_rob_addr.
- One sub-module: arb_starve_counter (saturating counter with inc/clr inputs and an at_limit output).
- The request latches use the existing register module.

Test Plan:
- Lone store:
  - stimulus: st_req with addr 0x0040, wdata 0xBEEF, wmask 2'b11; memory responds 3 cycles after the strobe;
  - expected: dmem_write at N+1 with exactly those values, constant for all 3 cycles; st_resp pulses with dmem_resp; then IDLE.
- Lone load:
  - stimulus: ld_req with addr 0x1000, tag 5; dmem_rdata = 0x1234;
  - expected: dmem_read at N+1; ld_resp with ld_rdata = 0x1234 and ld_tag_out = 5; st_resp stays 0.
- Simultaneous requests:
  - stimulus: st_req and ld_req both held high, each store followed by a new store;
  - expected: 4 store grants, then the load is granted on the 5th; starve_cnt clears; the following store is granted next.
- Flush during load:
  - stimulus: flush in the 2nd cycle of LOAD (tag 2), resp 2 cycles later;
  - expected: LOAD_DRAIN with dmem_read held; ld_resp never asserted; IDLE after resp.
- Flush with resp, and flush in IDLE:
  - stimulus: flush coincident with dmem_resp in LOAD; separately, flush in IDLE with ld_req and st_req both high;
  - expected: first case, no ld_resp; second case, the store is granted and the load is not.
- Reset mid-store:
  - stimulus: reset during STORE;
  - expected: next cycle state is IDLE, dmem_write = 0, and no st_resp even if dmem_resp arrives afterwards.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter.
//   lc3b_word        : 16-bit data/address word
//   lc3b_rob_addr    : ROB tag carried by speculative loads
//   lc3b_mem_wmask   : byte enables on the memory port
//   dmem_arb_state_t : arbiter FSM states
package dmem_port_arbiter_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_rob_addr;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        STORE      = 2'd1,
        LOAD       = 2'd2,
        LOAD_DRAIN = 2'd3
    } dmem_arb_state_t;

endpackage

// File: rtl/dmem_port_arbiter_starve.sv
// Saturating counter of consecutive store grants taken while a load waited.
//   clk, reset  : clock and synchronous reset (count returns to 0)
//   inc_i       : count one more store-over-load grant (saturates at LIMIT)
//   clr_i       : return to zero; wins over inc_i
//   count_o     : current count
//   at_limit_o  : count has reached LIMIT, the waiting load must win next
module arb_starve_counter #(
    parameter int LIMIT = 4,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_limit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_W'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o    = cnt_q;
    assign at_limit_o = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/register.sv
// Generic load-enabled register with synchronous active-high reset to zero.
//   clk, reset : clock and synchronous reset
//   load_i     : capture d_i on the next rising edge
//   d_i / q_o  : data in / registered data out
module register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the commit stage (stores) and the
// load unit (speculative loads). One transaction at a time; the memory-side
// address/data/mask come only from registers latched at grant time.
//
// Handshake: a requester raises *_req and holds it (with its payload) until
// its one-cycle *_resp pulse; a load may instead be dropped by flush. The
// memory side sees a level strobe (dmem_read/dmem_write) held until the
// cycle in which dmem_resp is high; that cycle completes the transaction.
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   st_req/st_addr/st_wdata/st_wmask: store request and payload
//   st_resp                         : store completion pulse
//   ld_req/ld_addr/ld_tag           : load request, address, ROB tag
//   ld_resp/ld_rdata/ld_tag_out     : load completion pulse, data, tag
//   flush                           : squash outstanding/pending loads
//   dmem_*                          : memory port
//   dbg_state_o, dbg_starve_cnt_o   : FSM state and starvation count
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int TAG_WIDTH    = 3,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  st_req,
    input  logic [DATA_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_wdata,
    input  lc3b_mem_wmask         st_wmask,
    output logic                  st_resp,

    input  logic                  ld_req,
    input  logic [DATA_WIDTH-1:0] ld_addr,
    input  logic [TAG_WIDTH-1:0]  ld_tag,
    output logic                  ld_resp,
    output logic [DATA_WIDTH-1:0] ld_rdata,
    output logic [TAG_WIDTH-1:0]  ld_tag_out,

    input  logic                  flush,

    output logic                  dmem_read,
    output logic                  dmem_write,
    output logic [DATA_WIDTH-1:0] dmem_address,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output lc3b_mem_wmask         dmem_wmask,
    input  logic                  dmem_resp,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,

    output dmem_arb_state_t       dbg_state_o,
    output logic [CNT_W-1:0]      dbg_starve_cnt_o
);

    dmem_arb_state_t state_q;
    dmem_arb_state_t state_d;

    logic grant_st;
    logic grant_ld;
    logic st_resp_c;
    logic ld_resp_c;
    logic at_limit;
    logic ld_ok;

    logic [DATA_WIDTH-1:0] addr_d,  addr_q;
    logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
    logic [1:0]            wmask_d, wmask_q;
    logic [TAG_WIDTH-1:0]  tag_d,   tag_q;
    logic                  latch_en;

    // A load is only eligible when no flush is squashing it this cycle.
    assign ld_ok = ld_req & ~flush;

    always_comb begin
        state_d    = state_q;
        grant_st   = 1'b0;
        grant_ld   = 1'b0;
        st_resp_c  = 1'b0;
        ld_resp_c  = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Stores win ties unless the waiting load has been passed
                // over STARVE_LIMIT times in a row.
                grant_st = st_req & ~(ld_ok & at_limit);
                grant_ld = ld_ok & (~st_req | at_limit);
                if (grant_st) begin
                    state_d = STORE;
                end else if (grant_ld) begin
                    state_d = LOAD;
                end
            end
            STORE: begin
                dmem_write = 1'b1;
                if (dmem_resp) begin
                    st_resp_c = 1'b1;
                    state_d   = IDLE;
                end
            end
            LOAD: begin
                dmem_read = 1'b1;
                if (dmem_resp) begin
                    ld_resp_c = ~flush;
                    state_d   = IDLE;
                end else if (flush) begin
                    state_d = LOAD_DRAIN;
                end
            end
            LOAD_DRAIN: begin
                // The read is already in flight; wait it out silently.
                dmem_read = 1'b1;
                if (dmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latches: captured only on a grant, so the memory-side
    // signals stay constant for the whole transaction.
    assign latch_en = grant_st | grant_ld;
    assign addr_d   = grant_st ? st_addr  : ld_addr;
    assign wdata_d  = grant_st ? st_wdata : '0;
    assign wmask_d  = grant_st ? st_wmask : 2'b00;
    assign tag_d    = grant_ld ? ld_tag   : '0;

    register #(.WIDTH(DATA_WIDTH)) u_addr_reg (
        .clk(clk), .reset(reset), .load_i(latch_en), .d_i(addr_d), .q_o(addr_q)
    );
    register #(.WIDTH(DATA_WIDTH)) u_wdata_reg (
        .clk(clk), .reset(reset), .load_i(latch_en), .d_i(wdata_d), .q_o(wdata_q)
    );
    register #(.WIDTH(2)) u_wmask_reg (
        .clk(clk), .reset(reset), .load_i(latch_en), .d_i(wmask_d), .q_o(wmask_q)
    );
    register #(.WIDTH(TAG_WIDTH)) u_tag_reg (
        .clk(clk), .reset(reset), .load_i(latch_en), .d_i(tag_d), .q_o(tag_q)
    );

    arb_starve_counter #(.LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_starve (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (grant_st & ld_req),
        .clr_i     (grant_ld | (grant_st & ~ld_req)),
        .count_o   (dbg_starve_cnt_o),
        .at_limit_o(at_limit)
    );

    // A reset abandons the transaction, so no response may escape during it.
    assign st_resp      = st_resp_c & ~reset;
    assign ld_resp      = ld_resp_c & ~reset;
    assign ld_rdata     = dmem_rdata;
    assign ld_tag_out   = tag_q;
    assign dmem_address = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_wmask   = (state_q == STORE) ? wmask_q : 2'b00;
    assign dbg_state_o  = state_q;

endmodule
